// File: rtl/pre_neuron_state_updater.sv
`default_nettype none
// ============================================================================
// Module   : pre_neuron_state_updater
// Purpose  : Bus master for the single-port pre-neuron state SRAM.
//            On START it visits every word once with a read-modify-write:
//            the 16-bit presynaptic trace decays, and for neurons flagged in
//            the latched spike bitmap the trace gets an increment and the
//            8-bit spike count is bumped (both saturating). When idle it
//            serves single-word host reads/writes to the same SRAM.
// Ports    : CK, RST                 clock / synchronous active-high reset
//            START, PRE_SPIKE        sweep request and spike bitmap
//            BUSY, DONE              sweep status
//            HOST_REQ/WE/ADDR/WDATA  host access request
//            HOST_RDATA, HOST_ACK    host access completion
//            SRAM_CS/WE/A/D, SRAM_Q  SRAM port (1-cycle registered read)
// Revision : 1.0 - initial release
// ============================================================================
module pre_neuron_state_updater #(
    parameter int          ADDR_WIDTH  = 8,
    parameter int          DATA_WIDTH  = 32,
    parameter int          SRAM_DEPTH  = 256,
    parameter int          DECAY_SHIFT = 3,
    parameter logic [15:0] TRACE_INC   = 16'h0400
) (
    input  logic                  CK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [SRAM_DEPTH-1:0] PRE_SPIKE,
    output logic                  BUSY,
    output logic                  DONE,
    input  logic                  HOST_REQ,
    input  logic                  HOST_WE,
    input  logic [ADDR_WIDTH-1:0] HOST_ADDR,
    input  logic [DATA_WIDTH-1:0] HOST_WDATA,
    output logic [DATA_WIDTH-1:0] HOST_RDATA,
    output logic                  HOST_ACK,
    output logic                  SRAM_CS,
    output logic                  SRAM_WE,
    output logic [ADDR_WIDTH-1:0] SRAM_A,
    output logic [DATA_WIDTH-1:0] SRAM_D,
    input  logic [DATA_WIDTH-1:0] SRAM_Q
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SRAM_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        WB    = 3'd2,
        FIN   = 3'd3,
        H_ACC = 3'd4,
        H_ACK = 3'd5
    } state_t;

    state_t                  r_state;
    state_t                  w_next;

    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [SRAM_DEPTH-1:0]   r_spike;
    logic                    r_host_we;
    logic [ADDR_WIDTH-1:0]   r_host_addr;
    logic [DATA_WIDTH-1:0]   r_host_wdata;
    logic [DATA_WIDTH-1:0]   r_rdata;

    // ------------------------------------------------------------------
    // Word update datapath (operates on the word read in the RD cycle)
    // ------------------------------------------------------------------
    logic [SRAM_DEPTH-1:0]   w_spike_vec;
    logic                    w_spike;
    logic [15:0]             w_trace;
    logic [7:0]              w_cnt;
    logic [16:0]             w_decayed;
    logic [16:0]             w_inc;
    logic [15:0]             w_new_trace;
    logic [7:0]              w_new_cnt;
    logic [DATA_WIDTH-1:0]   w_upd_word;

    // Shift instead of indexing so the counter width may exceed what the
    // bitmap strictly needs.
    assign w_spike_vec = r_spike >> r_addr;
    assign w_spike     = w_spike_vec[0];

    assign w_trace     = SRAM_Q[15:0];
    assign w_cnt       = SRAM_Q[23:16];
    // trace - (trace >> k) never exceeds trace, so bit 16 stays clear here;
    // the extra bit matters only once the increment is added.
    assign w_decayed   = {1'b0, w_trace} - {1'b0, w_trace >> DECAY_SHIFT};
    assign w_inc       = w_decayed + {1'b0, TRACE_INC};
    assign w_new_trace = !w_spike   ? w_decayed[15:0] :
                         w_inc[16]  ? 16'hFFFF        : w_inc[15:0];
    assign w_new_cnt   = (w_spike && (w_cnt != 8'hFF)) ? (w_cnt + 8'd1) : w_cnt;
    assign w_upd_word  = {SRAM_Q[DATA_WIDTH-1:24], w_new_cnt, w_new_trace};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next   = r_state;
        BUSY     = 1'b0;
        DONE     = 1'b0;
        HOST_ACK = 1'b0;
        SRAM_CS  = 1'b0;
        SRAM_WE  = 1'b0;
        SRAM_A   = '0;
        SRAM_D   = '0;
        case (r_state)
            IDLE: begin
                // START has priority; a pending host request waits out the sweep.
                if (START) begin
                    w_next = RD;
                end else if (HOST_REQ) begin
                    w_next = H_ACC;
                end
            end
            RD: begin
                BUSY    = 1'b1;
                SRAM_CS = 1'b1;
                SRAM_A  = r_addr;
                w_next  = WB;
            end
            WB: begin
                BUSY    = 1'b1;
                SRAM_CS = 1'b1;
                SRAM_WE = 1'b1;
                SRAM_A  = r_addr;
                SRAM_D  = w_upd_word;
                w_next  = (r_addr == LAST_ADDR) ? FIN : RD;
            end
            FIN: begin
                BUSY   = 1'b1;
                DONE   = 1'b1;
                w_next = IDLE;
            end
            H_ACC: begin
                SRAM_CS = 1'b1;
                SRAM_WE = r_host_we;
                SRAM_A  = r_host_addr;
                SRAM_D  = r_host_wdata;
                w_next  = H_ACK;
            end
            H_ACK: begin
                HOST_ACK = 1'b1;
                w_next   = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Read data is passed straight through during the ACK cycle and then
    // held from the capture register until the next ACK.
    assign HOST_RDATA = (r_state == H_ACK) ? SRAM_Q : r_rdata;

    // ------------------------------------------------------------------
    // Address counter, spike latch, host request registers
    // ------------------------------------------------------------------
    always_ff @(posedge CK) begin
        if (RST) begin
            r_addr       <= '0;
            r_spike      <= '0;
            r_host_we    <= 1'b0;
            r_host_addr  <= '0;
            r_host_wdata <= '0;
            r_rdata      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (START) begin
                        r_spike <= PRE_SPIKE;
                        r_addr  <= '0;
                    end else if (HOST_REQ) begin
                        r_host_we    <= HOST_WE;
                        r_host_addr  <= HOST_ADDR;
                        r_host_wdata <= HOST_WDATA;
                    end
                end
                WB: begin
                    // Counter stops at the last word instead of wrapping.
                    if (r_addr != LAST_ADDR) begin
                        r_addr <= r_addr + ADDR_WIDTH'(1);
                    end
                end
                H_ACK: begin
                    r_rdata <= SRAM_Q;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pre_neuron_state_updater.sv
`default_nettype none
// ============================================================================
// Module   : tb_pre_neuron_state_updater
// Purpose  : Randomized self-checking bench for pre_neuron_state_updater,
//            with an SRAM model and a word-level reference array.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pre_neuron_state_updater;

    localparam int          AW    = 4;
    localparam int          DW    = 32;
    localparam int          N     = 8;
    localparam int          DS    = 3;
    localparam logic [15:0] INC   = 16'h4000;
    localparam int          MEMSZ = 16;
    localparam int          SWEEP = 2 * N + 1;

    logic          CK = 1'b0;
    logic          RST = 1'b1;
    logic          START = 1'b0;
    logic [N-1:0]  PRE_SPIKE = '0;
    logic          BUSY, DONE;
    logic          HOST_REQ = 1'b0;
    logic          HOST_WE = 1'b0;
    logic [AW-1:0] HOST_ADDR = '0;
    logic [DW-1:0] HOST_WDATA = '0;
    logic [DW-1:0] HOST_RDATA;
    logic          HOST_ACK;
    logic          SRAM_CS, SRAM_WE;
    logic [AW-1:0] SRAM_A;
    logic [DW-1:0] SRAM_D;
    logic [DW-1:0] SRAM_Q;

    always #5 CK = ~CK;

    pre_neuron_state_updater #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .SRAM_DEPTH (N),
        .DECAY_SHIFT(DS),
        .TRACE_INC  (INC)
    ) dut (
        .CK        (CK),
        .RST       (RST),
        .START     (START),
        .PRE_SPIKE (PRE_SPIKE),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .HOST_REQ  (HOST_REQ),
        .HOST_WE   (HOST_WE),
        .HOST_ADDR (HOST_ADDR),
        .HOST_WDATA(HOST_WDATA),
        .HOST_RDATA(HOST_RDATA),
        .HOST_ACK  (HOST_ACK),
        .SRAM_CS   (SRAM_CS),
        .SRAM_WE   (SRAM_WE),
        .SRAM_A    (SRAM_A),
        .SRAM_D    (SRAM_D),
        .SRAM_Q    (SRAM_Q)
    );

    // SRAM model: registered read, read-before-write on the same edge.
    logic [DW-1:0] mem [MEMSZ];
    always @(posedge CK) begin
        if (SRAM_CS) begin
            SRAM_Q <= mem[SRAM_A];
            if (SRAM_WE) mem[SRAM_A] <= SRAM_D;
        end
    end

    logic [DW-1:0] ref_mem [MEMSZ];
    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference word update, from the word format with plain integer math.
    function automatic logic [31:0] upd(input logic [31:0] w, input bit s);
        int t, c;
        t = int'(w[15:0]);
        c = int'(w[23:16]);
        t = t - t / (2 ** DS);
        if (s) begin
            t = t + int'(INC);
            if (t > 65535) t = 65535;
            if (c < 255) c = c + 1;
        end
        return {w[31:24], 8'(c), 16'(t)};
    endfunction

    // Bus monitor
    logic [AW-1:0] addr_q [$];
    bit host_on  = 1'b0;
    int viol     = 0;
    int done_cnt = 0;
    int exp_done = 0;
    always @(negedge CK) begin
        if (SRAM_CS && BUSY) addr_q.push_back(SRAM_A);
        if (SRAM_WE && !SRAM_CS) viol++;
        if (SRAM_CS && !BUSY && !host_on) viol++;
        if (DONE) done_cnt++;
    end

    task automatic chk_seq();
        int bad = 0;
        if (addr_q.size() != 2 * N) bad = 1000;
        else for (int i = 0; i < 2 * N; i++) if (addr_q[i] != AW'(i / 2)) bad++;
        check("addr_seq", bad, 0);
        addr_q.delete();
    endtask

    task automatic chk_mem(input string tag);
        for (int i = 0; i < MEMSZ; i++) check(tag, mem[i], ref_mem[i]);
    endtask

    task automatic host(input bit we, input logic [AW-1:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int lat);
        @(negedge CK);
        host_on = 1'b1; HOST_REQ = 1'b1; HOST_WE = we; HOST_ADDR = a; HOST_WDATA = d;
        lat = -1; rd = '0;
        for (int c = 1; c <= 50 && lat < 0; c++) begin
            @(negedge CK);
            if (HOST_ACK) begin
                lat = c; rd = HOST_RDATA; HOST_REQ = 1'b0;
            end
        end
        HOST_REQ = 1'b0;
        host_on  = 1'b0;
        if (we) ref_mem[a] = d;
    endtask

    task automatic sweep(input logic [N-1:0] bm, input bit disturb);
        int cyc = 0, busy_cyc = 0, lat = -1;
        @(negedge CK);
        START = 1'b1; PRE_SPIKE = bm;
        while (lat < 0 && cyc < 200) begin
            @(negedge CK);
            cyc++;
            START = 1'b0;
            if (disturb && cyc == 5) begin START = 1'b1; PRE_SPIKE = ~bm; end
            if (disturb && cyc == 6) PRE_SPIKE = N'($urandom);
            if (BUSY) busy_cyc++;
            if (DONE) lat = cyc;
        end
        for (int i = 0; i < N; i++) ref_mem[i] = upd(ref_mem[i], bm[i]);
        exp_done++;
        check("done_lat", lat, SWEEP);
        check("busy_cycles", busy_cyc, SWEEP);
        repeat (4) @(negedge CK);
        check("done_count", done_cnt, exp_done);
        check("idle_busy", BUSY, 1'b0);
        chk_seq();
        chk_mem("sweep_word");
    endtask

    initial begin
        logic [31:0] rd, v;
        logic [N-1:0] bm;
        int lat, cyc, done_at, ack_at;

        repeat (3) @(negedge CK);
        check("rst_ctrl", {BUSY, DONE, HOST_ACK, SRAM_CS, SRAM_WE}, 5'b0);
        check("rst_addr", SRAM_A, 0);
        check("rst_wdata", SRAM_D, 0);
        check("rst_rdata", HOST_RDATA, 0);
        RST = 1'b0;

        // Fill the array through the host port, with a few corner words.
        for (int i = 0; i < MEMSZ; i++) begin
            case (i)
                0: v = 32'hAB00FFFF;
                1: v = 32'h00FF0000;
                2: v = 32'h00000000;
                3: v = 32'h00001000;
                default: v = $urandom;
            endcase
            host(1'b1, AW'(i), v, rd, lat);
            check("init_ack_lat", lat, 2);
        end

        // Host write returns the old word; read returns the new one and holds.
        host(1'b1, AW'(9), 32'h12345678, rd, lat);
        check("hw_ack_lat", lat, 2);
        host(1'b0, AW'(9), 32'h0, rd, lat);
        check("hr_ack_lat", lat, 2);
        check("hr_data", rd, 32'h12345678);
        repeat (2) @(negedge CK);
        check("hr_hold", HOST_RDATA, 32'h12345678);
        host(1'b1, AW'(9), 32'hCAFE0001, rd, lat);
        check("hw_old_word", rd, 32'h12345678);

        // Spikes on the saturating words 0/1, none on the zero word 2.
        bm = (N'($urandom) & ~N'(7)) | N'(3);
        sweep(bm, 1'b0);
        for (int k = 0; k < 3; k++) sweep(N'($urandom), 1'b0);
        // Extra START and bitmap churn mid-sweep must not matter.
        sweep(N'($urandom), 1'b1);

        // START and HOST_REQ together: sweep first, ACK after DONE.
        v = $urandom;
        bm = N'($urandom);
        @(negedge CK);
        host_on = 1'b1;
        START = 1'b1; PRE_SPIKE = bm;
        HOST_REQ = 1'b1; HOST_WE = 1'b1; HOST_ADDR = AW'(5); HOST_WDATA = v;
        cyc = 0; done_at = -1; ack_at = -1; rd = '0;
        while (ack_at < 0 && cyc < 200) begin
            @(negedge CK);
            cyc++;
            START = 1'b0;
            if (DONE) done_at = cyc;
            if (HOST_ACK) begin ack_at = cyc; rd = HOST_RDATA; HOST_REQ = 1'b0; end
        end
        HOST_REQ = 1'b0;
        host_on = 1'b0;
        for (int i = 0; i < N; i++) ref_mem[i] = upd(ref_mem[i], bm[i]);
        exp_done++;
        check("both_done_lat", done_at, SWEEP);
        check("both_ack_lat", ack_at, SWEEP + 3);
        check("both_old_word", rd, ref_mem[5]);
        ref_mem[5] = v;
        repeat (2) @(negedge CK);
        chk_seq();
        chk_mem("both_word");

        // Reset in the WB cycle of word 1: words 0 and 1 written, rest untouched.
        bm = N'($urandom);
        @(negedge CK);
        START = 1'b1; PRE_SPIKE = bm;
        for (int c = 1; c <= 4; c++) begin
            @(negedge CK);
            START = 1'b0;
        end
        RST = 1'b1;
        @(negedge CK);
        RST = 1'b0;
        check("mid_rst_ctrl", {BUSY, DONE, SRAM_CS, SRAM_WE}, 4'b0);
        check("mid_rst_addr", SRAM_A, 0);
        ref_mem[0] = upd(ref_mem[0], bm[0]);
        ref_mem[1] = upd(ref_mem[1], bm[1]);
        addr_q.delete();
        repeat (3) @(negedge CK);
        check("mid_rst_no_done", done_cnt, exp_done);
        chk_mem("mid_rst_word");
        sweep(N'($urandom), 1'b0);

        for (int k = 0; k < 4; k++) begin
            int a = $urandom_range(MEMSZ - 1);
            host(1'b0, AW'(a), 32'h0, rd, lat);
            check("final_read", rd, ref_mem[a]);
        end
        check("protocol_viol", viol, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
